// File: rtl/mac_seq_ctrl.sv
// Sequencer for a multi-mode MAC: latches a mode, streams operand beats into
// the datapath, waits for the pipeline to settle and presents the result.
// Optional macro MAC_SEQ_CFG_CHECK_EN rejects the reserved lane mode 2'b11.
module mac_seq_ctrl #(
  parameter int MAC_CONF_WIDTH = 4,
  parameter int MAC_MIN_WIDTH  = 8,
  parameter int PIPE_DEPTH     = 3,
  parameter int CNT_WIDTH      = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic [MAC_CONF_WIDTH-1:0]   cfg_in,
  input  logic [CNT_WIDTH-1:0]        acc_len,
  input  logic                        cfg_wr,
  output logic                        cfg_busy,
  output logic                        cfg_err,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [4*MAC_MIN_WIDTH-1:0]  in_a,
  input  logic [4*MAC_MIN_WIDTH-1:0]  in_b,
  output logic [MAC_CONF_WIDTH-1:0]   dp_cfg,
  output logic [4*MAC_MIN_WIDTH-1:0]  dp_a,
  output logic [4*MAC_MIN_WIDTH-1:0]  dp_b,
  output logic                        dp_valid,
  output logic                        dp_acc_clr,
  output logic                        dp_last,
  output logic                        res_valid,
  input  logic                        res_ready
);

  localparam int LANES_W = 4 * MAC_MIN_WIDTH;
  localparam int DRAIN_W = $clog2(PIPE_DEPTH + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
  localparam logic [DRAIN_W-1:0]   DRAIN_ONE = DRAIN_W'(1);
  localparam logic [DRAIN_W-1:0]   DRAIN_LD  = DRAIN_W'(PIPE_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_DRAIN  = 2'd2,
    S_RESULT = 2'd3
  } state_t;

  state_t                    state_q, state_d;
  logic [MAC_CONF_WIDTH-1:0] cfg_q, cfg_d;
  logic [CNT_WIDTH-1:0]      target_q, target_d;
  logic [CNT_WIDTH-1:0]      beat_q, beat_d;
  logic [DRAIN_W-1:0]        drain_q, drain_d;
  logic [LANES_W-1:0]        dpa_q, dpa_d;
  logic [LANES_W-1:0]        dpb_q, dpb_d;
  logic                      vld_q, vld_d;
  logic                      clr_q, clr_d;
  logic                      last_q, last_d;
  logic                      accept;
  logic                      is_last_beat;
  logic                      cfg_bad;

`ifdef MAC_SEQ_CFG_CHECK_EN
  logic err_q;

  assign cfg_bad = (cfg_in[1:0] == 2'b11);

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= (state_q == S_IDLE) && en && cfg_wr && cfg_bad;
  end

  assign cfg_err = err_q;
`else
  assign cfg_bad = 1'b0;
  assign cfg_err = 1'b0;
`endif

  assign in_ready     = (state_q == S_RUN) && en;
  assign accept       = in_ready && in_valid;
  assign is_last_beat = (beat_q == (target_q - CNT_ONE));

  always_comb begin
    state_d  = state_q;
    cfg_d    = cfg_q;
    target_d = target_q;
    beat_d   = beat_q;
    drain_d  = drain_q;
    dpa_d    = dpa_q;
    dpb_d    = dpb_q;
    vld_d    = 1'b0;
    clr_d    = 1'b0;
    last_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (en && cfg_wr && !cfg_bad) begin
          cfg_d    = cfg_in;
          target_d = (acc_len == '0) ? CNT_ONE : acc_len;
          beat_d   = '0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        if (accept) begin
          dpa_d  = in_a;
          dpb_d  = in_b;
          vld_d  = 1'b1;
          clr_d  = (beat_q == '0);
          last_d = is_last_beat;
          // Counter parks on target-1 at the final beat instead of wrapping.
          if (is_last_beat) begin
            state_d = S_DRAIN;
            drain_d = DRAIN_LD;
          end else begin
            beat_d  = beat_q + CNT_ONE;
          end
        end
      end
      S_DRAIN: begin
        if (en) begin
          if (drain_q <= DRAIN_ONE) begin
            drain_d = '0;
            state_d = S_RESULT;
          end else begin
            drain_d = drain_q - DRAIN_ONE;
          end
        end
      end
      S_RESULT: begin
        if (en && res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Register stage: control, counters and the one-cycle datapath beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cfg_q    <= '0;
      target_q <= '0;
      beat_q   <= '0;
      drain_q  <= '0;
      dpa_q    <= '0;
      dpb_q    <= '0;
      vld_q    <= 1'b0;
      clr_q    <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cfg_q    <= cfg_d;
      target_q <= target_d;
      beat_q   <= beat_d;
      drain_q  <= drain_d;
      dpa_q    <= dpa_d;
      dpb_q    <= dpb_d;
      vld_q    <= vld_d;
      clr_q    <= clr_d;
      last_q   <= last_d;
    end
  end

  assign cfg_busy   = (state_q != S_IDLE);
  assign res_valid  = (state_q == S_RESULT);
  assign dp_cfg     = cfg_q;
  assign dp_a       = dpa_q;
  assign dp_b       = dpb_q;
  assign dp_valid   = vld_q;
  assign dp_acc_clr = clr_q;
  assign dp_last    = last_q;

endmodule

// File: doc/mac_seq_ctrl.md
MAC_SEQ_CTRL -- requirements
Module: mac_seq_ctrl

Interface
REQ-001 The block SHALL expose these parameters (name, default, meaning):
- MAC_CONF_WIDTH, 4, cfg width: bit3 signed, bit2 mac/mul, bits1:0 single/dual/quad.
- MAC_MIN_WIDTH, 8, lane operand width.
- PIPE_DEPTH, 3, datapath latency in cycles from a dp beat to a settled accumulator (≥1).
- CNT_WIDTH, 8, beat-counter width.
REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1, sole clock; all logic on the rising edge.
- rst, in, 1, synchronous active-high reset.
- en, in, 1, global advance enable.
- cfg_in, in, MAC_CONF_WIDTH, requested datapath mode.
- acc_len, in, CNT_WIDTH, beats per accumulation.
- cfg_wr, in, 1, start request that latches cfg_in and acc_len.
- cfg_busy, out, 1, high whenever the state is not IDLE.
- cfg_err, out, 1, one-cycle pulse on a rejected cfg_wr (macro only).
- in_valid, in, 1, operand beat offered.
- in_ready, out, 1, operand beat accepted when high together with in_valid.
- in_a, in, 4*MAC_MIN_WIDTH, lanes A3..A0 (MSB lane 3).
- in_b, in, 4*MAC_MIN_WIDTH, lanes B3..B0 (MSB lane 3).
- dp_cfg, out, MAC_CONF_WIDTH, latched mode driven to the negator/multiplier.
- dp_a, out, 4*MAC_MIN_WIDTH, registered operand lanes A.
- dp_b, out, 4*MAC_MIN_WIDTH, registered operand lanes B.
- dp_valid, out, 1, dp_a/dp_b valid this cycle.
- dp_acc_clr, out, 1, first beat of an accumulation; the accumulator loads instead of adding.
- dp_last, out, 1, final beat of an accumulation.
- res_valid, in/out handshake, 1 (output), accumulator result stable.
- res_ready, in, 1, consumer takes the result.

Function
REQ-003 The block SHALL implement the states IDLE, RUN, DRAIN and RESULT.
REQ-004 IDLE: on cfg_wr=1 with en=1, the block SHALL latch cfg_in into dp_cfg, latch the beat target (acc_len==0 treated as 1), clear the beat counter and go to RUN.
REQ-005 cfg_wr outside IDLE SHALL be ignored; dp_cfg SHALL NOT change outside IDLE.
REQ-006 RUN: in_ready SHALL equal en, with no dependence on in_valid.
REQ-007 Each accepted beat SHALL register in_a/in_b into dp_a/dp_b and assert dp_valid for exactly the following cycle (1-cycle latency).
REQ-008 dp_acc_clr SHALL accompany beat index 0 and dp_last SHALL accompany beat index target-1; both SHALL be high together when the target is 1.
REQ-009 After the last beat is accepted, the block SHALL go to DRAIN with in_ready=0 and load the drain counter with PIPE_DEPTH.
REQ-010 DRAIN SHALL decrement the drain counter once per en cycle and enter RESULT when the counter reaches 0, so that res_valid rises PIPE_DEPTH+1 cycles after the last handshake when en stays high.
REQ-011 RESULT: res_valid SHALL stay high until res_valid&res_ready&en, then the block SHALL return to IDLE with res_valid=0 in the next cycle.
REQ-012 en=0 SHALL freeze the state and all counters, force in_ready=0 and dp_valid=0, and hold res_valid and dp_* data.
REQ-013 Outside a post-accept cycle, dp_valid, dp_acc_clr and dp_last SHALL be 0; dp_a/dp_b SHALL hold their last value.
REQ-014 The beat counter SHALL saturate at target-1 and never wrap.

Reset
REQ-015 On rst=1 at a clock edge, the state SHALL become IDLE, all counters SHALL become 0, and dp_cfg, dp_a, dp_b, dp_valid, dp_acc_clr, dp_last, res_valid, in_ready and cfg_err SHALL all become 0. cfg_busy SHALL be 0.
REQ-016 Reset SHALL take priority over en and over all handshakes; a reset mid-RUN or mid-DRAIN SHALL abandon the accumulation without asserting dp_last or res_valid.

Configuration
REQ-017 With MAC_SEQ_CFG_CHECK_EN defined, a cfg_wr in IDLE with cfg_in[1:0]==2'b11 SHALL pulse cfg_err for one cycle and leave the block in IDLE with dp_cfg unchanged.
REQ-018 Without MAC_SEQ_CFG_CHECK_EN, cfg_in[1:0]==2'b11 SHALL be accepted as-is (the datapath decodes it as single), and cfg_err SHALL be tied to 0.

Verification
REQ-019 Reset then idle: rst for 2 cycles, then cfg_wr=0 -> all outputs 0 and cfg_busy=0 for 10 cycles.
REQ-020 Basic burst: cfg_in=4'b1010, acc_len=3, PIPE_DEPTH=3, in_valid held high -> three dp_valid pulses (clr on 1st, last on 3rd), res_valid rises 4 cycles after the 3rd handshake, and dp_cfg=4'b1010 throughout.
REQ-021 Backpressure/stall: acc_len=2, en low for 2 cycles mid-RUN and res_ready low for 5 cycles -> no beat lost or duplicated, and res_valid holds until res_ready=1, then IDLE.
REQ-022 acc_len=0: single beat -> dp_acc_clr=dp_last=1 on the same dp_valid cycle.
REQ-023 Ignored reconfig and reset abort: cfg_wr with 4'b0001 during RUN leaves dp_cfg unchanged; rst during DRAIN -> res_valid never asserts and the block is in IDLE next cycle.
REQ-024 Macro: cfg_in=4'b0011 with cfg_wr -> with MAC_SEQ_CFG_CHECK_EN, cfg_err pulses once and the block stays in IDLE; without it, the block enters RUN with dp_cfg=4'b0011.
